// File: rtl/mem_stage_ctrl_if.sv
// mem_stage_ctrl_if: data-memory request/acknowledge bus between the M stage
// and the data memory.
//   req    master->slave  request pending (held until ack)
//   we     master->slave  1 = write, 0 = read
//   addr   master->slave  word-aligned byte address
//   wdata  master->slave  store data
//   rdata  slave->master  load data, valid with ack
//   ack    slave->master  one-cycle completion pulse
interface mem_stage_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;

  modport master (output req, we, addr, wdata, input rdata, ack);
  modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: memory (M) stage of the 5-stage pipeline.
// Takes the EX/MEM register outputs, runs a variable-latency data-memory
// access over the dmem bus, stalls upstream while it is outstanding, loads
// the MEM/WB register and supplies the M-stage forwarding value.
//
// Ports:
//   clk, reset           clock; synchronous active-high reset
//   *_m inputs           EX/MEM control and data
//   dmem                 memory bus (master side), outputs registered
//   stall_m              freezes PC, IF/ID, ID/EX, EX/MEM
//   fwd_data_m           forwarding value to execute stage (combinational)
//   *_w outputs          MEM/WB register
//   mem_err              sticky access-timeout flag
//
// Build option: define MEM_TIMEOUT_EN to abort a BUSY access after
// TIMEOUT_CYCLES cycles without ack; otherwise BUSY waits indefinitely and
// mem_err is tied 0.
//
// state | meaning
// IDLE  | no access outstanding; non-memory ops pass through in one cycle
// BUSY  | request on the bus, waiting for ack
// DONE  | data captured, pipeline released, MEM/WB loads
module mem_stage_ctrl #(
  parameter int DATA_W         = 32,
  parameter int REG_W          = 5,
  parameter int PC_W           = 5,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_read_m,
  input  logic                  mem_write_m,
  input  logic                  mem_to_reg_m,
  input  logic                  reg_write_m,
  input  logic                  jal_m,
  input  logic [DATA_W-1:0]     alu_result_m,
  input  logic [DATA_W-1:0]     write_data_m,
  input  logic [REG_W-1:0]      reg_dst_m,
  input  logic [PC_W-1:0]       pc_m,
  mem_stage_ctrl_if.master      dmem,
  output logic                  stall_m,
  output logic [DATA_W-1:0]     fwd_data_m,
  output logic                  reg_write_w,
  output logic                  mem_to_reg_w,
  output logic                  jal_w,
  output logic [DATA_W-1:0]     read_data_w,
  output logic [DATA_W-1:0]     alu_result_w,
  output logic [REG_W-1:0]      reg_dst_w,
  output logic [PC_W-1:0]       pc_w,
  output logic                  mem_err
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e            state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_buf_q, rdata_buf_d;
  logic              reg_write_w_q, reg_write_w_d;
  logic              mem_to_reg_w_q, mem_to_reg_w_d;
  logic              jal_w_q, jal_w_d;
  logic [DATA_W-1:0] read_data_w_q, read_data_w_d;
  logic [DATA_W-1:0] alu_result_w_q, alu_result_w_d;
  logic [REG_W-1:0]  reg_dst_w_q, reg_dst_w_d;
  logic [PC_W-1:0]   pc_w_q, pc_w_d;
  logic              stall_int;
  logic              mem_op;
  logic              ack_hit;
  logic              timeout_hit;

  assign mem_op  = mem_read_m | mem_write_m;
  // Ack only counts while waiting, so a stretched or stray ack is harmless.
  assign ack_hit = (state_q == S_BUSY) && dmem.ack;

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       mem_err_q, mem_err_d;
  // Ack in the same cycle as the timeout takes priority.
  assign timeout_hit = (state_q == S_BUSY) && !dmem.ack && (wait_cnt_q == TO_LAST);
  assign mem_err     = mem_err_q;
`else
  assign timeout_hit = 1'b0;
  assign mem_err     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      req_q          <= 1'b0;
      we_q           <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      rdata_buf_q    <= '0;
      reg_write_w_q  <= 1'b0;
      mem_to_reg_w_q <= 1'b0;
      jal_w_q        <= 1'b0;
      read_data_w_q  <= '0;
      alu_result_w_q <= '0;
      reg_dst_w_q    <= '0;
      pc_w_q         <= '0;
`ifdef MEM_TIMEOUT_EN
      wait_cnt_q     <= '0;
      mem_err_q      <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      req_q          <= req_d;
      we_q           <= we_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      rdata_buf_q    <= rdata_buf_d;
      reg_write_w_q  <= reg_write_w_d;
      mem_to_reg_w_q <= mem_to_reg_w_d;
      jal_w_q        <= jal_w_d;
      read_data_w_q  <= read_data_w_d;
      alu_result_w_q <= alu_result_w_d;
      reg_dst_w_q    <= reg_dst_w_d;
      pc_w_q         <= pc_w_d;
`ifdef MEM_TIMEOUT_EN
      wait_cnt_q     <= wait_cnt_d;
      mem_err_q      <= mem_err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (mem_op) state_d = S_BUSY;
      S_BUSY:  if (ack_hit || timeout_hit) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    stall_int   = 1'b0;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_buf_d = rdata_buf_q;
`ifdef MEM_TIMEOUT_EN
    wait_cnt_d  = wait_cnt_q;
    mem_err_d   = mem_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (mem_op) begin
          stall_int = 1'b1;
          req_d     = 1'b1;
          we_d      = mem_write_m;
          addr_d    = {alu_result_m[DATA_W-1:2], 2'b00};
          wdata_d   = write_data_m;
`ifdef MEM_TIMEOUT_EN
          wait_cnt_d = '0;
`endif
        end
      end
      S_BUSY: begin
        stall_int = 1'b1;
        if (ack_hit) begin
          req_d       = 1'b0;
          // Stores write back zero rather than whatever the bus returned.
          rdata_buf_d = we_q ? '0 : dmem.rdata;
        end else if (timeout_hit) begin
          req_d       = 1'b0;
          rdata_buf_d = DATA_W'(32'hDEADBEEF);
`ifdef MEM_TIMEOUT_EN
          mem_err_d   = 1'b1;
`endif
        end else begin
`ifdef MEM_TIMEOUT_EN
          wait_cnt_d = wait_cnt_q + 8'd1;
`endif
        end
      end
      default: ;
    endcase

    // Bubble into MEM/WB while stalled; data fields simply hold.
    reg_write_w_d  = 1'b0;
    mem_to_reg_w_d = 1'b0;
    jal_w_d        = 1'b0;
    read_data_w_d  = read_data_w_q;
    alu_result_w_d = alu_result_w_q;
    reg_dst_w_d    = reg_dst_w_q;
    pc_w_d         = pc_w_q;
    if (!stall_int) begin
      reg_write_w_d  = reg_write_m;
      mem_to_reg_w_d = mem_to_reg_m;
      jal_w_d        = jal_m;
      read_data_w_d  = (state_q == S_DONE) ? rdata_buf_q : '0;
      alu_result_w_d = alu_result_m;
      reg_dst_w_d    = reg_dst_m;
      pc_w_d         = pc_m;
    end
  end

  assign stall_m    = stall_int & ~reset;
  assign fwd_data_m = jal_m ? {{(DATA_W-PC_W){1'b0}}, pc_m} : alu_result_m;

  assign dmem.req     = req_q;
  assign dmem.we      = we_q;
  assign dmem.addr    = addr_q;
  assign dmem.wdata   = wdata_q;
  assign reg_write_w  = reg_write_w_q;
  assign mem_to_reg_w = mem_to_reg_w_q;
  assign jal_w        = jal_w_q;
  assign read_data_w  = read_data_w_q;
  assign alu_result_w = alu_result_w_q;
  assign reg_dst_w    = reg_dst_w_q;
  assign pc_w         = pc_w_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
module tb_mem_stage_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read_m, mem_write_m, mem_to_reg_m, reg_write_m, jal_m;
  logic [31:0] alu_result_m, write_data_m;
  logic [4:0]  reg_dst_m, pc_m;
  logic        stall_m;
  logic [31:0] fwd_data_m;
  logic        reg_write_w, mem_to_reg_w, jal_w;
  logic [31:0] read_data_w, alu_result_w;
  logic [4:0]  reg_dst_w, pc_w;
  logic        mem_err;
  int          total = 0;
  int          bad = 0;
  int          stall_cnt;

  mem_stage_ctrl_if #(.DATA_W(32)) dmem_if ();

  mem_stage_ctrl #(.DATA_W(32), .REG_W(5), .PC_W(5), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .mem_read_m(mem_read_m), .mem_write_m(mem_write_m), .mem_to_reg_m(mem_to_reg_m),
    .reg_write_m(reg_write_m), .jal_m(jal_m), .alu_result_m(alu_result_m),
    .write_data_m(write_data_m), .reg_dst_m(reg_dst_m), .pc_m(pc_m),
    .dmem(dmem_if.master), .stall_m(stall_m), .fwd_data_m(fwd_data_m),
    .reg_write_w(reg_write_w), .mem_to_reg_w(mem_to_reg_w), .jal_w(jal_w),
    .read_data_w(read_data_w), .alu_result_w(alu_result_w), .reg_dst_w(reg_dst_w),
    .pc_w(pc_w), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    mem_read_m = 0; mem_write_m = 0; mem_to_reg_m = 0; reg_write_m = 0; jal_m = 0;
    alu_result_m = 0; write_data_m = 0; reg_dst_m = 0; pc_m = 0;
  endtask

  initial begin
    nop();
    dmem_if.ack = 0;
    dmem_if.rdata = 0;
    reset = 1;
    tick(); tick();
    // Reset: registered state cleared, stall masked, forwarding live.
    mem_read_m = 1; alu_result_m = 32'h0000_0abc;
    #1;
    chk("rst_stall", 32'(stall_m), 32'd0);
    chk("rst_fwd", fwd_data_m, 32'h0000_0abc);
    chk("rst_req", 32'(dmem_if.req), 32'd0);
    chk("rst_addr", dmem_if.addr, 32'd0);
    chk("rst_rw", 32'(reg_write_w), 32'd0);
    chk("rst_rd", read_data_w, 32'd0);
    chk("rst_err", 32'(mem_err), 32'd0);
    nop();
    tick();
    reset = 0;

    // ADD
    alu_result_m = 32'h10; reg_dst_m = 8; reg_write_m = 1;
    #1;
    chk("add_stall", 32'(stall_m), 32'd0);
    chk("add_fwd", fwd_data_m, 32'h10);
    tick();
    chk("add_alu_w", alu_result_w, 32'h10);
    chk("add_dst_w", 32'(reg_dst_w), 32'd8);
    chk("add_rw_w", 32'(reg_write_w), 32'd1);
    chk("add_req", 32'(dmem_if.req), 32'd0);

    // JAL
    nop();
    jal_m = 1; pc_m = 5'd20; alu_result_m = 32'h99; reg_write_m = 1; reg_dst_m = 31;
    #1;
    chk("jal_fwd", fwd_data_m, 32'h14);
    tick();
    chk("jal_pc_w", 32'(pc_w), 32'd20);
    chk("jal_jal_w", 32'(jal_w), 32'd1);

    // Load, ack in first BUSY cycle
    nop();
    mem_read_m = 1; mem_to_reg_m = 1; reg_write_m = 1; alu_result_m = 32'h43; reg_dst_m = 9;
    #1;
    chk("ld_stall_idle", 32'(stall_m), 32'd1);
    tick();
    chk("ld_req", 32'(dmem_if.req), 32'd1);
    chk("ld_we", 32'(dmem_if.we), 32'd0);
    chk("ld_addr", dmem_if.addr, 32'h40);
    chk("ld_bubble_rw", 32'(reg_write_w), 32'd0);
    chk("ld_stall_busy", 32'(stall_m), 32'd1);
    dmem_if.ack = 1; dmem_if.rdata = 32'hCAFEF00D;
    tick();
    dmem_if.ack = 0; dmem_if.rdata = 0;
    #1;
    chk("ld_stall_done", 32'(stall_m), 32'd0);
    chk("ld_req_done", 32'(dmem_if.req), 32'd0);
    chk("ld_bubble_rw2", 32'(reg_write_w), 32'd0);
    tick();
    nop();
    chk("ld_rd_w", read_data_w, 32'hCAFEF00D);
    chk("ld_m2r_w", 32'(mem_to_reg_w), 32'd1);
    chk("ld_rw_w", 32'(reg_write_w), 32'd1);
    chk("ld_dst_w", 32'(reg_dst_w), 32'd9);
    tick();
    chk("ld_after_rd", read_data_w, 32'd0);

    // Store, ack in 4th BUSY cycle; ack left high into DONE is ignored
    mem_write_m = 1; write_data_m = 32'h12345678; alu_result_m = 32'h107; reg_dst_m = 12;
    stall_cnt = 0;
    #1;
    if (stall_m) stall_cnt++;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("st_req", 32'(dmem_if.req), 32'd1);
      chk("st_we", 32'(dmem_if.we), 32'd1);
      chk("st_wdata", dmem_if.wdata, 32'h12345678);
      chk("st_addr", dmem_if.addr, 32'h104);
      if (stall_m) stall_cnt++;
      if (i == 3) begin dmem_if.ack = 1; dmem_if.rdata = 32'h5555_5555; end
      tick();
    end
    if (stall_m) stall_cnt++;
    chk("st_stall_cycles", 32'(stall_cnt), 32'd5);
    chk("st_rw_bubble", 32'(reg_write_w), 32'd0);
    tick();
    nop();
    chk("st_rd_w", read_data_w, 32'd0);
    chk("st_dst_w", 32'(reg_dst_w), 32'd12);
    tick();
    dmem_if.ack = 0;
    #1;
    chk("st_stray_ack_req", 32'(dmem_if.req), 32'd0);
    chk("st_stray_ack_stall", 32'(stall_m), 32'd0);

    // Read and write together: handled as store, mem_to_reg still passes
    mem_read_m = 1; mem_write_m = 1; mem_to_reg_m = 1; reg_write_m = 1; alu_result_m = 32'h20;
    tick();
    chk("rw_we", 32'(dmem_if.we), 32'd1);
    dmem_if.ack = 1; dmem_if.rdata = 32'h77;
    tick();
    tick();
    nop();
    dmem_if.ack = 0;
    chk("rw_rd_w", read_data_w, 32'd0);
    chk("rw_m2r_w", 32'(mem_to_reg_w), 32'd1);

    // Reset in 2nd BUSY cycle, ack one cycle later
    mem_read_m = 1; mem_to_reg_m = 1; reg_write_m = 1; alu_result_m = 32'h200;
    tick();
    tick();
    reset = 1;
    nop();
    tick();
    reset = 0;
    dmem_if.ack = 1; dmem_if.rdata = 32'h0BAD;
    #1;
    chk("rb_req", 32'(dmem_if.req), 32'd0);
    chk("rb_stall", 32'(stall_m), 32'd0);
    tick();
    dmem_if.ack = 0;
    chk("rb_rd_w", read_data_w, 32'd0);
    chk("rb_rw_w", 32'(reg_write_w), 32'd0);
    chk("rb_req2", 32'(dmem_if.req), 32'd0);

`ifdef MEM_TIMEOUT_EN
    // Timeout after 4 BUSY cycles
    mem_read_m = 1; mem_to_reg_m = 1; reg_write_m = 1; alu_result_m = 32'h300;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("to_stall", 32'(stall_m), 32'd1);
      tick();
    end
    chk("to_err", 32'(mem_err), 32'd1);
    chk("to_req", 32'(dmem_if.req), 32'd0);
    tick();
    nop();
    chk("to_rd_w", read_data_w, 32'hDEADBEEF);
    tick(); tick();
    chk("to_sticky", 32'(mem_err), 32'd1);
    reset = 1;
    tick();
    reset = 0;
    chk("to_err_rst", 32'(mem_err), 32'd0);
    // Ack on the timeout cycle wins
    mem_read_m = 1; mem_to_reg_m = 1; reg_write_m = 1; alu_result_m = 32'h300;
    tick();
    tick(); tick(); tick();
    dmem_if.ack = 1; dmem_if.rdata = 32'h1111;
    tick();
    dmem_if.ack = 0;
    chk("to_ack_err", 32'(mem_err), 32'd0);
    tick();
    nop();
    chk("to_ack_rd", read_data_w, 32'h1111);
    tick();
`else
    // Without the timeout, BUSY waits as long as it takes
    mem_read_m = 1; mem_to_reg_m = 1; reg_write_m = 1; alu_result_m = 32'h300;
    tick();
    for (int i = 0; i < 20; i++) tick();
    chk("nto_stall", 32'(stall_m), 32'd1);
    chk("nto_req", 32'(dmem_if.req), 32'd1);
    chk("nto_err", 32'(mem_err), 32'd0);
    dmem_if.ack = 1; dmem_if.rdata = 32'h2222;
    tick();
    dmem_if.ack = 0;
    tick();
    nop();
    chk("nto_rd_w", read_data_w, 32'h2222);
    chk("nto_err2", 32'(mem_err), 32'd0);
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
